sram_1rw_arbiter: RTL and testbench
===================================

Name: sram_1rw_arbiter

Overview:
- Shares one single-port 1RW SRAM macro (256 x 47, one-cycle registered-address read) between NREQ requesters.
- Round-robin arbitration; at most one SRAM access per cycle.
- Writes are fire-and-forget; read data returns on a per-requester valid/ready response buffer.
- Sits between the macro and client pipelines (e.g. table or BTB update and lookup ports).

Parameters:
- NREQ, 2, number of requesters (2..4).
- ADDR_W, 8, SRAM address width.
- DATA_W, 47, SRAM data width.
- DEPTH, 256, SRAM entries; equals 2**ADDR_W.

Ports:
- clock  in  1  sole clock; rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request present, per requester.
- req_ready  out  NREQ  request granted this cycle.
- req_wmode  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*ADDR_W  flattened; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*DATA_W  flattened write data.
- resp_valid  out  NREQ  read data available.
- resp_ready  in  NREQ  consumer accepts read data.
- resp_rdata  out  NREQ*DATA_W  flattened read data.
- sram_en  out  1  to macro RW0_en.
- sram_wmode  out  1  to macro RW0_wmode.
- sram_addr  out  ADDR_W  to macro RW0_addr.
- sram_wdata  out  DATA_W  to macro RW0_wdata.
- sram_rdata  in  DATA_W  from macro RW0_rdata.
- init_busy  out  1  array zero-fill in progress; 0 when SRAM_ARB_INIT_EN is absent.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - resp_valid = 0, inflight_valid = 0, rr_ptr = 0.
  - sram_en = 0 and req_ready = 0 while reset is high.
  - A read in flight at reset is discarded.
  - Response buffers are cleared.
- Eligibility:
  - A write from i is always eligible.
  - A read from i is eligible iff (!resp_valid[i] || resp_ready[i]) && !(inflight_valid && inflight_id == i).
- Grant:
  - Pick the first eligible, valid requester searching from rr_ptr upward, modulo NREQ.
  - req_ready is one-hot or zero and is combinational from the grant.
  - Requesters must not make req_valid depend on req_ready.
  - A handshake completes when req_valid[i] && req_ready[i].
- rr_ptr updates only on a grant: rr_ptr <= (granted id + 1) mod NREQ.
- SRAM drive:
  - sram_en = any grant.
  - sram_wmode, sram_addr and sram_wdata come from the granted requester, combinationally.
  - With no grant, addr and wdata hold don't-care values.
- Read pipeline:
  - Grant read in cycle T: set inflight_valid = 1 and inflight_id = i.
  - In T+1, sram_rdata is valid; it is captured into resp buffer i at the end of T+1.
  - resp_valid[i] rises in T+2. Grant-to-response latency is 2 cycles.
  - sram_rdata is never sampled without inflight_valid (the macro may return garbage).
- Response buffer:
  - Holds data while resp_valid && !resp_ready.
  - Pops at the end of a cycle where resp_valid && resp_ready.
  - A pop and a load to the same buffer in one cycle is impossible by the eligibility rule.
- Throughput:
  - One access per cycle in aggregate.
  - A single requester streams writes at 1/cycle and reads at 1 per 2 cycles.
- Write then read, same address, consecutive grants: the read returns the new data.
- Read and write ordering within one requester follows grant order.
- No ordering is guaranteed across requesters beyond grant order.

Optional Feature:
- Macro: SRAM_ARB_INIT_EN.
- Defined:
  - 2-state FSM, INIT -> RUN.
  - Reset enters INIT with init_cnt = 0.
  - INIT drives sram_en = 1, wmode = 1, addr = init_cnt, wdata = 0 every cycle.
  - req_ready = 0 and init_busy = 1 throughout INIT.
  - After address DEPTH-1 is written, move to RUN. INIT lasts exactly DEPTH cycles.
  - Reset during INIT restarts at 0.
- Not defined: FSM is absent, the block starts in RUN, init_busy is tied 0.

Decomposition:
- Package sram_arb_pkg: ADDR_W, DATA_W, DEPTH and NREQ defaults; state enum {ST_INIT, ST_RUN}; id width constant clog2(NREQ).
- Sub-module rr_arbiter: combinational round-robin picker plus the rr_ptr register.
  - Inputs: eligible-and-valid vector, grant-taken.
  - Outputs: one-hot grant, granted id.
- The top level holds the eligibility logic, inflight register, response buffers and the optional init FSM.

Test Plan:
1. Reset, then req0 writes 0x1234 to addr 0x05 in cycle 10 and req0 reads 0x05 in cycle 11 -> resp_valid[0] in cycle 13 with rdata 0x1234; sram_en is high in cycles 10 and 11 only.
2. Both requesters hold continuous writes from cycle 0 with rr_ptr = 0 -> grants alternate 0, 1, 0, 1; each requester gets 50%.
3. req1 reads addr 0x10 while resp_ready[1] is held 0 -> resp_valid[1] stays high, data stable; a further req1 read gets no grant until the pop, while req0 writes are still granted.
4. One requester issues reads back-to-back -> grants every other cycle only, no data loss or overwrite.
5. Reset asserted the cycle after a read grant -> no resp_valid appears; rr_ptr = 0; the first grant after reset goes to req0 when both request.
6. With SRAM_ARB_INIT_EN defined: after reset, init_busy is high for exactly 256 cycles and req_ready stays 0; then reading addr 0xFF returns 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared defaults, FSM state type and id-width helper for the 1RW SRAM arbiter.
package sram_arb_pkg;

   localparam int NREQ_DEF   = 2;
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 47;
   localparam int DEPTH_DEF  = 256;

   typedef enum logic {ST_INIT, ST_RUN} arbState_e;

   // A single requester still needs a one-bit id field.
   function automatic int idWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int ID_W_DEF = idWidth(NREQ_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker; the pointer moves one past the winner on each taken grant.
module rr_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int ID_W = idWidth(NREQ)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [NREQ-1:0] req_i,
   input  logic            take_i,
   output logic [NREQ-1:0] grant_o,
   output logic [ID_W-1:0] grantId_o
);

   logic [ID_W-1:0] rrPtr_q, rrPtr_d;
   logic            found;
   int              idx;

   always_comb begin
      grant_o   = '0;
      grantId_o = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rrPtr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         for (int i = 0; i < NREQ; i++) begin
            if (i == idx && !found && req_i[i]) begin
               found      = 1'b1;
               grant_o[i] = 1'b1;
               grantId_o  = ID_W'(i);
            end
         end
      end
   end

   always_comb begin
      rrPtr_d = rrPtr_q;
      if (take_i && found) begin
         rrPtr_d = (grantId_o == ID_W'(NREQ - 1)) ? '0 : grantId_o + ID_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) rrPtr_q <= '0;
      else       rrPtr_q <= rrPtr_d;
   end

endmodule

// File: rtl/sram_1rw_arbiter.sv
// Round-robin sharing of one 1RW SRAM macro between NREQ requesters with per-requester read buffers.
// Define SRAM_ARB_INIT_EN to zero-fill the array after reset before serving requests.
module sram_1rw_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NREQ   = NREQ_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ-1:0]          req_wmode,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          resp_valid,
   input  logic [NREQ-1:0]          resp_ready,
   output logic [NREQ*DATA_W-1:0]   resp_rdata,
   output logic                     sram_en,
   output logic                     sram_wmode,
   output logic [ADDR_W-1:0]        sram_addr,
   output logic [DATA_W-1:0]        sram_wdata,
   input  logic [DATA_W-1:0]        sram_rdata,
   output logic                     init_busy
);

   localparam int ID_W = idWidth(NREQ);

   if (DEPTH != (1 << ADDR_W)) begin : gDepthCheck
      $error("DEPTH must equal 2**ADDR_W");
   end

   logic [NREQ-1:0]              eligible, candidates, grant;
   logic [ID_W-1:0]              grantId;
   logic                         grantValid, grantWmode, readGrant, runActive;
   logic [ADDR_W-1:0]            grantAddr;
   logic [DATA_W-1:0]            grantWdata;
   logic                         inflightValid_q;
   logic [ID_W-1:0]              inflightId_q;
   logic [NREQ-1:0]              respValid_q, respValid_d;
   logic [NREQ-1:0][DATA_W-1:0]  respData_q, respData_d;

`ifdef SRAM_ARB_INIT_EN
   arbState_e         state_q, state_d;
   logic [ADDR_W-1:0] initCnt_q, initCnt_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_INIT;
         initCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         initCnt_q <= initCnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      initCnt_d = initCnt_q;
      case (state_q)
         ST_INIT: begin
            initCnt_d = initCnt_q + ADDR_W'(1);
            if (initCnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
         end
         default: ;
      endcase
   end

   assign init_busy = (state_q == ST_INIT);
   assign runActive = (state_q == ST_RUN) && !reset;
`else
   assign init_busy = 1'b0;
   assign runActive = !reset;
`endif

   // A read may only issue when its buffer will be free and none is already headed there.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NREQ; i++) begin
         eligible[i] = req_valid[i] &&
                       (req_wmode[i] ||
                        ((!respValid_q[i] || resp_ready[i]) &&
                         !(inflightValid_q && inflightId_q == ID_W'(i))));
      end
   end

   assign candidates = eligible & {NREQ{runActive}};

   rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_rr (
      .clock     (clock),
      .reset     (reset),
      .req_i     (candidates),
      .take_i    (runActive),
      .grant_o   (grant),
      .grantId_o (grantId)
   );

   assign req_ready  = grant;
   assign grantValid = |grant;
   assign readGrant  = grantValid && !grantWmode;

   always_comb begin
      grantWmode = 1'b0;
      grantAddr  = '0;
      grantWdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grantId == ID_W'(i)) begin
            grantWmode = req_wmode[i];
            grantAddr  = req_addr[i*ADDR_W +: ADDR_W];
            grantWdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      sram_en    = grantValid;
      sram_wmode = grantWmode;
      sram_addr  = grantAddr;
      sram_wdata = grantWdata;
`ifdef SRAM_ARB_INIT_EN
      if (state_q == ST_INIT && !reset) begin
         sram_en    = 1'b1;
         sram_wmode = 1'b1;
         sram_addr  = initCnt_q;
         sram_wdata = '0;
      end
`endif
   end

   always_comb begin
      respValid_d = respValid_q;
      respData_d  = respData_q;
      for (int i = 0; i < NREQ; i++) begin
         if (respValid_q[i] && resp_ready[i]) respValid_d[i] = 1'b0;
         if (inflightValid_q && inflightId_q == ID_W'(i)) begin
            respValid_d[i] = 1'b1;
            respData_d[i]  = sram_rdata;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         inflightValid_q <= 1'b0;
         inflightId_q    <= '0;
         respValid_q     <= '0;
         respData_q      <= '0;
      end else begin
         inflightValid_q <= readGrant;
         if (readGrant) inflightId_q <= grantId;
         respValid_q     <= respValid_d;
         respData_q      <= respData_d;
      end
   end

   assign resp_valid = respValid_q;
   assign resp_rdata = respData_q;

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Bench for sram_1rw_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_sram_1rw_arbiter;

   localparam int NREQ   = 2;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 47;
   localparam int DEPTH  = 256;
`ifdef SRAM_ARB_INIT_EN
   localparam int INIT_CYCLES = DEPTH;
`else
   localparam int INIT_CYCLES = 0;
`endif

   logic                   clock = 1'b0;
   logic                   reset;
   logic [NREQ-1:0]        req_valid, req_ready, req_wmode, resp_valid, resp_ready;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_wdata, resp_rdata;
   logic                   sram_en, sram_wmode, init_busy;
   logic [ADDR_W-1:0]      sram_addr;
   logic [DATA_W-1:0]      sram_wdata, sram_rdata;

   always #5 clock = ~clock;

   sram_1rw_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wmode  (req_wmode),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .sram_en    (sram_en),
      .sram_wmode (sram_wmode),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .init_busy  (init_busy)
   );

   // Macro stand-in: registered read, garbage on any cycle without a read.
   logic [DATA_W-1:0] macMem [DEPTH];
   logic [63:0]       garbage;
   always @(posedge clock) begin
      garbage = {$urandom(), $urandom()};
      if (sram_en && sram_wmode) macMem[sram_addr] <= sram_wdata;
      if (sram_en && !sram_wmode) sram_rdata <= macMem[sram_addr];
      else                        sram_rdata <= garbage[DATA_W-1:0];
   end

   logic [DATA_W-1:0] refMem [DEPTH];
   logic [NREQ-1:0]   mRespValid;
   logic [DATA_W-1:0] mRespData [NREQ];
   bit                pendValid;
   int                pendId;
   logic [DATA_W-1:0] pendData;
   int                rrPtr;
   int                initLeft;
   int                assertCount = 0;
   int                failCount   = 0;
   logic [NREQ-1:0]   lastReady;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock cycle: drive after the falling edge, check mid-cycle, advance the model at the rising edge.
   task automatic applyStimulus(input logic r, input logic [1:0] v, input logic [1:0] wm,
                                input logic [7:0] a0, input logic [7:0] a1,
                                input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                                input logic [1:0] rr);
      int gid;
      int ii;
      logic [1:0] expReady;
      logic [7:0] ga;
      logic [DATA_W-1:0] gd;
      reset      = r;
      req_valid  = v;
      req_wmode  = wm;
      req_addr   = {a1, a0};
      req_wdata  = {d1, d0};
      resp_ready = rr;
      #2;
      gid = -1;
      if (!r && initLeft == 0) begin
         for (int k = 0; k < NREQ; k++) begin
            ii = (rrPtr + k) % NREQ;
            if (gid < 0 && v[ii] &&
                (wm[ii] || ((!mRespValid[ii] || rr[ii]) && !(pendValid && pendId == ii))))
               gid = ii;
         end
      end
      expReady = (gid >= 0) ? (2'b01 << gid) : 2'b00;
      ga = (gid == 1) ? a1 : a0;
      gd = (gid == 1) ? d1 : d0;
      lastReady = req_ready;
      checkOutput("req_ready", 64'(req_ready), 64'(expReady));
      checkOutput("resp_valid", 64'(resp_valid), 64'(mRespValid));
      for (int i = 0; i < NREQ; i++)
         if (mRespValid[i]) checkOutput("resp_rdata", 64'(resp_rdata[i*DATA_W +: DATA_W]), 64'(mRespData[i]));
      if (r) begin
         checkOutput("sram_en_reset", 64'(sram_en), 64'(0));
      end else if (initLeft > 0) begin
         checkOutput("init_busy_high", 64'(init_busy), 64'(1));
         checkOutput("init_en", 64'(sram_en), 64'(1));
         checkOutput("init_wmode", 64'(sram_wmode), 64'(1));
         checkOutput("init_addr", 64'(sram_addr), 64'(DEPTH - initLeft));
         checkOutput("init_wdata", 64'(sram_wdata), 64'(0));
      end else begin
         checkOutput("init_busy_low", 64'(init_busy), 64'(0));
         checkOutput("sram_en", 64'(sram_en), 64'(gid >= 0));
         if (gid >= 0) begin
            checkOutput("sram_wmode", 64'(sram_wmode), 64'(wm[gid]));
            checkOutput("sram_addr", 64'(sram_addr), 64'(ga));
            if (wm[gid]) checkOutput("sram_wdata", 64'(sram_wdata), 64'(gd));
         end
      end
      @(posedge clock);
      if (r) begin
         mRespValid = '0;
         pendValid  = 1'b0;
         rrPtr      = 0;
         initLeft   = INIT_CYCLES;
      end else if (initLeft > 0) begin
         refMem[DEPTH - initLeft] = '0;
         initLeft--;
      end else begin
         for (int i = 0; i < NREQ; i++)
            if (mRespValid[i] && rr[i]) mRespValid[i] = 1'b0;
         if (pendValid) begin
            mRespValid[pendId] = 1'b1;
            mRespData[pendId]  = pendData;
         end
         pendValid = 1'b0;
         if (gid >= 0) begin
            if (wm[gid]) refMem[ga] = gd;
            else begin
               pendValid = 1'b1;
               pendId    = gid;
               pendData  = refMem[ga];
            end
            rrPtr = (gid + 1) % NREQ;
         end
      end
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 2'b00, 8'h0, 8'h0, '0, '0, 2'b11);
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 2'b11, 2'b10, 8'h3, 8'h4, 47'h1, 47'h2, 2'b11);
      idle(INIT_CYCLES);
   endtask

   logic [63:0] rnd0, rnd1;
   int cnt0, cnt1;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         rnd0 = {$urandom(), $urandom()};
         macMem[i] = rnd0[DATA_W-1:0];
         refMem[i] = rnd0[DATA_W-1:0];
      end
      mRespValid = '0;
      pendValid  = 1'b0;
      pendId     = 0;
      pendData   = '0;
      rrPtr      = 0;
      initLeft   = INIT_CYCLES;
      for (int i = 0; i < NREQ; i++) mRespData[i] = '0;
      reset = 1'b1; req_valid = '0; req_wmode = '0; req_addr = '0; req_wdata = '0; resp_ready = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      doReset();

`ifdef SRAM_ARB_INIT_EN
      applyStimulus(1'b0, 2'b01, 2'b00, 8'hFF, 8'h0, '0, '0, 2'b00);
      idle(1);
      checkOutput("init_read_valid", 64'(resp_valid[0]), 64'(1));
      checkOutput("init_read_zero", 64'(resp_rdata[DATA_W-1:0]), 64'(0));
      idle(1);
`endif

      // Write then read the same address on consecutive grants.
      idle(3);
      applyStimulus(1'b0, 2'b01, 2'b01, 8'h05, 8'h0, 47'h1234, '0, 2'b11);
      applyStimulus(1'b0, 2'b01, 2'b00, 8'h05, 8'h0, '0, '0, 2'b11);
      applyStimulus(1'b0, 2'b00, 2'b00, 8'h0, 8'h0, '0, '0, 2'b00);
      checkOutput("wr_rd_valid", 64'(resp_valid), 64'(2'b01));
      checkOutput("wr_rd_data", 64'(resp_rdata[DATA_W-1:0]), 64'h1234);
      idle(2);

      // Continuous writes from both share the port evenly.
      doReset();
      cnt0 = 0; cnt1 = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 2'b11, 2'b11, 8'(i), 8'(i + 8), 47'(i), 47'(i + 100), 2'b11);
         if (i == 0) checkOutput("first_grant_req0", 64'(lastReady), 64'(2'b01));
         cnt0 += int'(lastReady[0]);
         cnt1 += int'(lastReady[1]);
      end
      checkOutput("wr_share0", 64'(cnt0), 64'(4));
      checkOutput("wr_share1", 64'(cnt1), 64'(4));

      // A held response blocks further reads from its owner but not writes from others.
      applyStimulus(1'b0, 2'b10, 2'b00, 8'h0, 8'h10, '0, '0, 2'b00);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 2'b11, 2'b01, 8'(i + 32), 8'h11, 47'(i + 7), '0, 2'b00);
         checkOutput("held_grant_req0", 64'(lastReady), 64'(2'b01));
      end
      checkOutput("held_valid", 64'(resp_valid[1]), 64'(1));
      applyStimulus(1'b0, 2'b10, 2'b00, 8'h0, 8'h11, '0, '0, 2'b10);
      idle(3);

      // Back-to-back reads from one requester issue every other cycle.
      cnt0 = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 2'b01, 2'b00, 8'(i), 8'h0, '0, '0, 2'b01);
         cnt0 += int'(lastReady[0]);
      end
      checkOutput("rd_stream_grants", 64'(cnt0), 64'(4));
      idle(3);

      // Reset right after a read grant drops the read.
      applyStimulus(1'b0, 2'b10, 2'b00, 8'h0, 8'h20, '0, '0, 2'b11);
      doReset();
      idle(3);
      applyStimulus(1'b0, 2'b11, 2'b11, 8'h40, 8'h41, 47'h55, 47'h66, 2'b11);
      checkOutput("post_reset_req0", 64'(lastReady), 64'(2'b01));

      // Random traffic on a small address window to force collisions.
      for (int n = 0; n < 400; n++) begin
         rnd0 = {$urandom(), $urandom()};
         rnd1 = {$urandom(), $urandom()};
         if ($urandom_range(0, 199) == 0) doReset();
         else applyStimulus(1'b0, 2'($urandom()), 2'($urandom()),
                            8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                            rnd0[DATA_W-1:0], rnd1[DATA_W-1:0],
                            {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)});
      end
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #2000000;
      failCount++;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
